// File: rtl/video_timing_pkg.sv
// Shared timing defaults and colour-bar table for the video timing generator.
// The colour-bar feature is enabled with the VTG_TEST_PATTERN_EN macro.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 58;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 16;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_CW       = 9;

  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam int NUM_BARS = 8;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [NUM_BARS-1:0][23:0] BAR_RGB = {
    24'h000000,
    24'h0000FF,
    24'hFF0000,
    24'hFF00FF,
    24'h00FF00,
    24'h00FFFF,
    24'hFFFF00,
    24'hFFFFFF
  };

endpackage

// File: rtl/vtg_pattern.sv
// Colour-bar generator: eight equal-width vertical bars across the active area,
// registered so its latency matches the timing outputs.
module vtg_pattern
  import video_timing_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic          clk,
  input  logic          i_run,
  input  logic          i_active,
  input  logic [CW-1:0] i_hc,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  logic [2:0]  w_bar;
  logic [23:0] w_rgb;
  logic [23:0] r_rgb;

  // Bar index is the number of bar boundaries already passed, avoiding a divider.
  always_comb begin
    w_bar = '0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (i_hc >= CW'(i * BAR_W)) begin
        w_bar = 3'(i);
      end
    end
  end

  assign w_rgb = BAR_RGB[w_bar];

  always_ff @(posedge clk) begin
    if (!i_run || !i_active) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign o_r = r_rgb[23:16];
  assign o_g = r_rgb[15:8];
  assign o_b = r_rgb[7:0];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the pixel-clock domain; idles until PLL lock.
// Define VTG_TEST_PATTERN_EN to add r/g/b colour-bar outputs.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          locked,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0]    r_lk;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;

  logic          w_run;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_hblank;
  logic          w_vblank;
  logic          w_hsync;
  logic          w_vsync;

  logic          r_hsync_n;
  logic          r_vsync_n;
  logic          r_hblank;
  logic          r_vblank;
  logic          r_de;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  // locked comes from the PLL's own domain; two flops before it is trusted.
  always_ff @(posedge clk) begin
    r_lk <= {r_lk[0], locked};
  end

  assign w_run    = rst_n && r_lk[1];
  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);

  // Losing run abandons the current line immediately; restart is always at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n || !r_lk[1]) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_last) begin
      r_hc <= '0;
      r_vc <= w_v_last ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  assign w_hblank = (r_hc >= H_ACT_END);
  assign w_vblank = (r_vc >= V_ACT_END);
  assign w_hsync  = (r_hc >= HS_START) && (r_hc < HS_END);
  // vc only moves as hc wraps to 0, so vsync edges land on line starts.
  assign w_vsync  = (r_vc >= VS_START) && (r_vc < VS_END);

  always_ff @(posedge clk) begin
    if (!rst_n || !r_lk[1]) begin
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync_n     <= !w_hsync;
      r_vsync_n     <= !w_vsync;
      r_hblank      <= w_hblank;
      r_vblank      <= w_vblank;
      r_de          <= !w_hblank && !w_vblank;
      r_x           <= r_hc;
      r_y           <= r_vc;
      r_line_start  <= (r_hc == '0);
      r_frame_start <= (r_hc == '0) && (r_vc == '0);
    end
  end

  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VTG_TEST_PATTERN_EN
  logic w_active;

  assign w_active = !w_hblank && !w_vblank;

  vtg_pattern #(
    .CW       (CW),
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .clk      (clk),
    .i_run    (w_run),
    .i_active (w_active),
    .i_hc     (r_hc),
    .o_r      (r),
    .o_g      (g),
    .o_b      (b)
  );
`endif

endmodule
